// File: rtl/bit_packer_if.sv
// Handshake bundle between the bit source, the packer and the word consumer.
// The master side drives bits, flush and out_ready; the slave side is the packer.
interface bit_packer_if #(
   parameter int WIDTH = 8
);
   localparam int CW = $clog2(WIDTH + 1);

   logic          in_valid;
   logic          in_bit;
   logic          in_ready;
   logic          flush;
   logic          flush_busy;
   logic          out_valid;
   logic          out_ready;
   logic [WIDTH-1:0] out_data;
   logic [CW-1:0] out_count;

   modport master (
      output in_valid, in_bit, flush, out_ready,
      input  in_ready, flush_busy, out_valid,
      input  out_data, out_count
   );

   modport slave (
      input  in_valid, in_bit, flush, out_ready,
      output in_ready, flush_busy, out_valid,
      output out_data, out_count
   );
endinterface

// File: rtl/bit_packer.sv
// Packs a stream of decoded bits into WIDTH-bit words on a valid/ready
// output register, with a flush that emits a partial word and its bit count.
module bit_packer #(
   parameter int WIDTH     = 8,
   parameter bit MSB_FIRST = 1'b1
) (
   input logic         clk,
   input logic         rst,
   bit_packer_if.slave bus
);
   localparam int CW = $clog2(WIDTH + 1);
   localparam int IW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
   localparam logic [IW-1:0] TOP  = IW'(WIDTH - 1);

   logic [WIDTH-1:0] acc, acc_n, acc_w;
   logic [CW-1:0]    cnt, cnt_n, cnt_eff;
   logic             ov_q, ov_n;
   logic [WIDTH-1:0] od_q, od_n;
   logic [CW-1:0]    oc_q, oc_n;
   logic             fp_q, fp_n;
   logic             in_ready;
   logic             accept;
   logic             want_flush;
   logic             do_flush;
   logic [IW-1:0]    pos;

   // The only stall: one bit short of a word while the output slot is full.
   assign in_ready   = !(cnt == LAST && ov_q);
   assign accept     = bus.in_valid && in_ready;
   assign want_flush = fp_q || bus.flush;
   assign do_flush   = want_flush && (!ov_q || bus.out_ready);

   assign bus.in_ready   = in_ready;
   assign bus.flush_busy = fp_q;
   assign bus.out_valid  = ov_q;
   assign bus.out_data   = od_q;
   assign bus.out_count  = oc_q;

   always_comb begin
      pos     = MSB_FIRST ? TOP - cnt[IW-1:0] : cnt[IW-1:0];
      acc_w   = acc;
      if (accept) acc_w[pos] = bus.in_bit;
      cnt_eff = cnt + {{(CW-1){1'b0}}, accept};
      acc_n   = acc_w;
      cnt_n   = cnt_eff;
      ov_n    = ov_q && !bus.out_ready;
      od_n    = od_q;
      oc_n    = oc_q;
      fp_n    = want_flush && !do_flush;
      // A full word and a non-empty flush both load the freed slot.
      if ((accept && cnt == LAST) ||
          (do_flush && cnt_eff != '0)) begin
         od_n  = acc_w;
         oc_n  = cnt_eff;
         ov_n  = 1'b1;
         acc_n = '0;
         cnt_n = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         acc  <= '0;
         cnt  <= '0;
         ov_q <= 1'b0;
         od_q <= '0;
         oc_q <= '0;
         fp_q <= 1'b0;
      end else begin
         acc  <= acc_n;
         cnt  <= cnt_n;
         ov_q <= ov_n;
         od_q <= od_n;
         oc_q <= oc_n;
         fp_q <= fp_n;
      end
   end
endmodule

// File: tb/tb_bit_packer.sv
// Directed bench for bit_packer: MSB-first and LSB-first instances,
// words checked against a queue of expected results at each transfer.
module tb_bit_packer;
   typedef struct {
      logic [7:0] d;
      logic [3:0] c;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   failures = 0;
   exp_t qm[$];
   exp_t ql[$];

   always #5 clk = ~clk;

   bit_packer_if #(.WIDTH(8)) m_if ();
   bit_packer_if #(.WIDTH(8)) l_if ();

   bit_packer #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_m (
      .clk(clk), .rst(rst), .bus(m_if.slave)
   );
   bit_packer #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_l (
      .clk(clk), .rst(rst), .bus(l_if.slave)
   );

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h",
                tag, obs, exp);
      end
   endtask

   task automatic push_m(input logic [7:0] d, input logic [3:0] c);
      exp_t e;
      e.d = d;
      e.c = c;
      qm.push_back(e);
   endtask

   // Scoreboard: compare every word at the cycle it transfers.
   always @(negedge clk) begin
      if (!rst && m_if.out_valid && m_if.out_ready) begin
         if (qm.size() == 0) begin
            chk("m_unexpected_word", {24'd0, m_if.out_data}, 32'hx);
         end else begin
            exp_t e;
            e = qm.pop_front();
            chk("m_word_data", {24'd0, m_if.out_data}, {24'd0, e.d});
            chk("m_word_count", {28'd0, m_if.out_count}, {28'd0, e.c});
         end
      end
   end

   always @(negedge clk) begin
      if (!rst && l_if.out_valid && l_if.out_ready) begin
         if (ql.size() == 0) begin
            chk("l_unexpected_word", {24'd0, l_if.out_data}, 32'hx);
         end else begin
            exp_t e;
            e = ql.pop_front();
            chk("l_word_data", {24'd0, l_if.out_data}, {24'd0, e.d});
            chk("l_word_count", {28'd0, l_if.out_count}, {28'd0, e.c});
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic m_bit(input logic b);
      m_if.in_valid = 1'b1;
      m_if.in_bit   = b;
      step();
      m_if.in_valid = 1'b0;
   endtask

   task automatic m_byte(input logic [7:0] v);
      for (int i = 7; i >= 0; i--) m_bit(v[i]);
   endtask

   task automatic m_flush();
      m_if.flush = 1'b1;
      step();
      m_if.flush = 1'b0;
   endtask

   initial begin
      exp_t e;
      logic [7:0] v;
      m_if.in_valid = 0; m_if.in_bit = 0;
      m_if.flush = 0; m_if.out_ready = 1;
      l_if.in_valid = 0; l_if.in_bit = 0;
      l_if.flush = 0; l_if.out_ready = 1;
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
      chk("rst_out_valid", {31'd0, m_if.out_valid}, 32'd0);
      chk("rst_out_data", {24'd0, m_if.out_data}, 32'd0);
      chk("rst_out_count", {28'd0, m_if.out_count}, 32'd0);
      chk("rst_in_ready", {31'd0, m_if.in_ready}, 32'd1);
      chk("rst_flush_busy", {31'd0, m_if.flush_busy}, 32'd0);

      // Full word, MSB first
      push_m(8'hB2, 4'd8);
      m_byte(8'hB2);
      chk("msb_valid", {31'd0, m_if.out_valid}, 32'd1);
      chk("msb_data", {24'd0, m_if.out_data}, 32'hB2);
      step();
      chk("msb_valid_drop", {31'd0, m_if.out_valid}, 32'd0);

      // Same bits, LSB first
      e.d = 8'h4D;
      e.c = 4'd8;
      ql.push_back(e);
      v = 8'hB2;
      for (int i = 7; i >= 0; i--) begin
         l_if.in_valid = 1'b1;
         l_if.in_bit   = v[i];
         step();
      end
      l_if.in_valid = 1'b0;
      chk("lsb_data", {24'd0, l_if.out_data}, 32'h4D);
      step();
      chk("lsb_valid_drop", {31'd0, l_if.out_valid}, 32'd0);

      // Partial flush, then an empty flush
      m_bit(1); m_bit(1); m_bit(0);
      push_m(8'hC0, 4'd3);
      m_flush();
      chk("flush_valid", {31'd0, m_if.out_valid}, 32'd1);
      chk("flush_count", {28'd0, m_if.out_count}, 32'd3);
      chk("flush_busy_low", {31'd0, m_if.flush_busy}, 32'd0);
      step();
      m_flush();
      chk("empty_flush_valid", {31'd0, m_if.out_valid}, 32'd0);
      chk("empty_flush_busy", {31'd0, m_if.flush_busy}, 32'd0);

      // Back-pressure stall on the 8th bit of the next word
      m_if.out_ready = 1'b0;
      push_m(8'hB2, 4'd8);
      m_byte(8'hB2);
      for (int i = 0; i < 7; i++) m_bit(1);
      chk("stall_in_ready", {31'd0, m_if.in_ready}, 32'd0);
      m_if.in_valid = 1'b1;
      m_if.in_bit   = 1'b1;
      step();
      step();
      chk("stall_hold_data", {24'd0, m_if.out_data}, 32'hB2);
      chk("stall_hold_valid", {31'd0, m_if.out_valid}, 32'd1);
      chk("stall_in_ready2", {31'd0, m_if.in_ready}, 32'd0);
      push_m(8'hFF, 4'd8);
      m_if.out_ready = 1'b1;
      step();
      chk("unstall_valid", {31'd0, m_if.out_valid}, 32'd0);
      chk("unstall_in_ready", {31'd0, m_if.in_ready}, 32'd1);
      step();
      m_if.in_valid = 1'b0;
      chk("unstall_data", {24'd0, m_if.out_data}, 32'hFF);
      chk("unstall_valid2", {31'd0, m_if.out_valid}, 32'd1);
      step();

      // Flush waits for the output slot
      m_if.out_ready = 1'b0;
      push_m(8'hA5, 4'd8);
      m_byte(8'hA5);
      m_bit(1); m_bit(0);
      m_flush();
      chk("pend_busy", {31'd0, m_if.flush_busy}, 32'd1);
      step();
      step();
      chk("pend_busy2", {31'd0, m_if.flush_busy}, 32'd1);
      chk("pend_hold", {24'd0, m_if.out_data}, 32'hA5);
      push_m(8'h80, 4'd2);
      m_if.out_ready = 1'b1;
      step();
      chk("pend_data", {24'd0, m_if.out_data}, 32'h80);
      chk("pend_count", {28'd0, m_if.out_count}, 32'd2);
      chk("pend_busy_low", {31'd0, m_if.flush_busy}, 32'd0);
      step();

      // Reset discards a held word, partial bits and a pending flush
      m_if.out_ready = 1'b0;
      m_byte(8'hF0);
      for (int i = 0; i < 5; i++) m_bit(1);
      m_flush();
      chk("pre_rst_busy", {31'd0, m_if.flush_busy}, 32'd1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("rst2_valid", {31'd0, m_if.out_valid}, 32'd0);
      chk("rst2_data", {24'd0, m_if.out_data}, 32'd0);
      chk("rst2_count", {28'd0, m_if.out_count}, 32'd0);
      chk("rst2_busy", {31'd0, m_if.flush_busy}, 32'd0);
      chk("rst2_in_ready", {31'd0, m_if.in_ready}, 32'd1);
      m_if.out_ready = 1'b1;
      push_m(8'h3C, 4'd8);
      m_byte(8'h3C);
      chk("post_rst_data", {24'd0, m_if.out_data}, 32'h3C);
      step();
      step();

      chk("m_queue_drained", qm.size(), 32'd0);
      chk("l_queue_drained", ql.size(), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/bit_packer.md
Name: bit_packer

Overview:
- Downstream stage for the 1-bit decoder output `y`.
- Collects a stream of single decoded bits into WIDTH-bit words and presents them on a valid/ready output register.
- Supports an explicit flush that emits a partial word together with its valid-bit count.
- Sits between the per-symbol case decoder and the word-oriented consumer logic.

Parameters:
- WIDTH, 8: word width in bits; legal range 2..32.
- MSB_FIRST, 1: 1 = first received bit lands in out_data[WIDTH-1]; 0 = first bit lands in out_data[0].

Ports:
- clk, input, 1: single clock; all state updates on its rising edge.
- rst, input, 1: synchronous, active-high reset.
- in_valid, input, 1: in_bit is valid this cycle.
- in_bit, input, 1: decoded bit from the upstream decoder.
- in_ready, output, 1: packer accepts in_bit this cycle.
- flush, input, 1: single-cycle request to emit the partial word.
- out_valid, output, 1: out_data/out_count hold a word.
- out_ready, input, 1: consumer accepts the word this cycle.
- out_data, output, WIDTH: packed word.
- out_count, output, CW (CW = $clog2(WIDTH+1)): number of valid bits in out_data (1..WIDTH).
- flush_busy, output, 1: a flush is pending and not yet performed.

Behaviour:
Internal state:
- acc[WIDTH-1:0]: accumulator.
- cnt[CW-1:0]: bits held in acc (0..WIDTH-1).
- out register: out_valid, out_data, out_count.
- flush_pend flag.

Reset (rst=1 at a clock edge):
- acc=0, cnt=0, flush_pend=0, out_valid=0, out_data=0, out_count=0.
- An in-progress word or pending flush is discarded, with no partial emission.
- Immediately after reset, in_ready=1 and flush_busy=0.

Input acceptance:
- Accept occurs when in_valid && in_ready.
- in_ready = !(cnt==WIDTH-1 && out_valid).
- in_ready is purely combinational from registers. There is no path from out_ready to in_ready.

Bit placement:
- On accept with MSB_FIRST=1: acc[WIDTH-1-cnt] <= in_bit.
- On accept with MSB_FIRST=0: acc[cnt] <= in_bit.
- Unwritten positions of acc are always 0.

Word completion:
- A word completes when an accepted bit arrives with cnt==WIDTH-1. On that edge:
  - out_data <= acc including the new bit.
  - out_count <= WIDTH.
  - out_valid <= 1.
  - acc <= 0, cnt <= 0.
- Latency: completing bit accepted at edge N -> out_valid=1 after edge N (visible in cycle N+1).
- Completion can only occur when out_valid=0, guaranteed by the in_ready rule.

Output handshake:
- A word transfers when out_valid && out_ready.
- Without a new load, out_valid <= 0 on that edge.
- out_data and out_count hold their values while out_valid && !out_ready.
- The consumer may hold out_ready low indefinitely.

Flush:
- flush=1 sets flush_pend. flush_busy = flush_pend.
- The flush is performed on the first edge where flush_pend (or flush this cycle) is true and the output slot is free (out_valid==0, or out_valid && out_ready this cycle). On that edge:
  - If the effective count (cnt plus a bit accepted this cycle) is > 0: out_data <= acc including that bit, out_count <= effective count, out_valid <= 1, acc/cnt cleared.
  - If the effective count is 0: no-op.
  - In both cases flush_pend <= 0.
- A bit accepted on the same edge as a performed flush is included in the flushed word.
- If that bit completes a word, the result is a normal full word (out_count=WIDTH) and the flush is consumed.
- Bits keep being accepted while flush_pend waits, subject to in_ready, and are included in the eventual flush.
- flush asserted while flush_pend=1 has no extra effect.

State summary:
- EMPTY: cnt==0, out_valid==0.
- FILLING: cnt>0.
- HOLD: out_valid==1.
- STALL: HOLD with cnt==WIDTH-1, in_ready=0.
- Transitions follow the rules above.

Invariants:
- cnt never reaches WIDTH in a register.
- out_count is never 0 while out_valid=1.
- No bit is dropped or duplicated.

Test Plan:
- WIDTH=8, MSB_FIRST=1, out_ready=1; bits 1,0,1,1,0,0,1,0 on consecutive cycles -> one cycle after the 8th bit, out_valid=1, out_data=8'hB2, out_count=8; out_valid=0 on the next cycle.
- Same bits with MSB_FIRST=0 -> out_data=8'h4D, out_count=8.
- MSB_FIRST=1; bits 1,1,0, then flush pulse -> out_data=8'hC0, out_count=3, flush_busy low afterwards. A flush with cnt=0 -> no out_valid, flush_busy drops after one cycle.
- out_ready=0 holding 8'hB2; feed 7 more bits of 8'hFF -> in_ready=0 after the 7th, 8th bit stalls, out_data stable. Raise out_ready -> 8'hB2 transfers, 8th bit accepted next cycle, then out_data=8'hFF.
- flush asserted while out_valid=1, out_ready=0, cnt=2 (bits 1,0) -> flush_busy=1 until out_ready=1. On that edge the next word is loaded with out_data=8'h80, out_count=2, and flush_busy goes 0.
- rst=1 after 5 bits accepted with flush pending -> next cycle out_valid=0, out_data=0, out_count=0, flush_busy=0, in_ready=1. A following 8-bit sequence packs from bit 0 with no residue.
